shreg_arbiter: RTL

- Two-requester round-robin arbiter and burst sequencer for the shared 4-bit bidirectional shift register (en_left / en_right / Din interface).
- Grants the register to one client at a time and issues BURST consecutive shifts in that client's direction.
- Reports completion or abort to the client.
- Sits between the password-detector FSM (client A) and a second consumer such as a display/scroll unit (client B), in front of the shift register.

---
 rtl/shreg_pkg.sv | 17 +
 rtl/rr_pick2.sv | 23 ++
 rtl/shreg_arbiter.sv | 107 ++++++++++
 3 files changed

// File: rtl/shreg_pkg.sv
// Shared encodings for the shift-register arbiter: FSM states, shift
// directions and client indices.
package shreg_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SHIFT   = 2'd1,
    RELEASE = 2'd2
  } state_t;

  localparam logic DIR_LEFT  = 1'b0;
  localparam logic DIR_RIGHT = 1'b1;

  localparam logic CL_A = 1'b0;
  localparam logic CL_B = 1'b1;

endpackage

// File: rtl/rr_pick2.sv
// Two-way round-robin winner select: a lone requester wins, a tie goes to
// the client that was not served last.
module rr_pick2
  import shreg_pkg::*;
(
  input  logic req_a,
  input  logic req_b,
  input  logic last_served,
  output logic win_valid,
  output logic win
);

  always_comb begin
    win_valid = req_a | req_b;
    win       = CL_A;
    if (req_a && req_b) begin
      win = (last_served == CL_A) ? CL_B : CL_A;
    end else if (req_b) begin
      win = CL_B;
    end
  end

endmodule

// File: rtl/shreg_arbiter.sv
// Round-robin arbiter and burst sequencer for the shared bidirectional shift
// register: grants one client at a time and issues BURST shifts for it.
module shreg_arbiter
  import shreg_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int BURST = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_a,
  input  logic             dir_a,
  input  logic [WIDTH-1:0] din_a,
  input  logic             req_b,
  input  logic             dir_b,
  input  logic [WIDTH-1:0] din_b,
  output logic             gnt_a,
  output logic             gnt_b,
  output logic             en_left,
  output logic             en_right,
  output logic [WIDTH-1:0] Din,
  output logic             done,
  output logic             abort
);

  localparam logic [3:0] LAST = 4'(BURST - 1);

  state_t           state;
  logic [3:0]       cnt;
  logic             owner;
  logic             last_served;
  logic             dir_q;
  logic             done_flag;
  logic             abort_flag;
  logic             win_valid;
  logic             win;
  logic             req_own;
  logic [WIDTH-1:0] din_own;
  logic             shifting;

  rr_pick2 u_pick (
    .req_a       (req_a),
    .req_b       (req_b),
    .last_served (last_served),
    .win_valid   (win_valid),
    .win         (win)
  );

  assign req_own  = (owner == CL_B) ? req_b : req_a;
  assign din_own  = (owner == CL_B) ? din_b : din_a;
  assign shifting = (state == SHIFT) && req_own;

  // Data and enables follow the owner's live request; direction is the latched one.
  assign gnt_a    = (state == SHIFT) && (owner == CL_A);
  assign gnt_b    = (state == SHIFT) && (owner == CL_B);
  assign en_left  = shifting && (dir_q == DIR_LEFT);
  assign en_right = shifting && (dir_q == DIR_RIGHT);
  assign Din      = shifting ? din_own : '0;
  assign done     = (state == RELEASE) && done_flag;
  assign abort    = (state == RELEASE) && abort_flag;

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      cnt         <= 4'd0;
      owner       <= CL_A;
      last_served <= CL_B;
      dir_q       <= DIR_LEFT;
      done_flag   <= 1'b0;
      abort_flag  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (win_valid) begin
            owner      <= win;
            dir_q      <= (win == CL_B) ? dir_b : dir_a;
            cnt        <= 4'd0;
            done_flag  <= 1'b0;
            abort_flag <= 1'b0;
            state      <= SHIFT;
          end
        end
        SHIFT: begin
          if (req_own) begin
            if (cnt == LAST) begin
              done_flag <= 1'b1;
              state     <= RELEASE;
            end else begin
              cnt <= cnt + 4'd1;
            end
          end else begin
            abort_flag <= 1'b1;
            state      <= RELEASE;
          end
        end
        RELEASE: begin
          done_flag   <= 1'b0;
          abort_flag  <= 1'b0;
          last_served <= owner;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
